// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: arbiter FSM states, master-id width helper,
// and the data/address widths used by the masters and the slaves.
package bus_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Width of a master index; never narrower than one bit.
  function automatic int MASTER_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester found scanning upward
// from (last_owner + 1) mod MASTERS.
module rr_select
  import bus_pkg::*;
#(
  parameter int  MASTERS = 2,
  localparam int ID_W    = MASTER_ID_W(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  logic [ID_W-1:0]    cand [MASTERS];
  logic [MASTERS-1:0] cand_req;

  // cand[k] is the master examined at search position k.
  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_cand
      assign cand[gi]     = ID_W'((int'(last_owner) + 1 + gi) % MASTERS);
      assign cand_req[gi] = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        winner = cand[i];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared serial slave bus with a one-cycle turnaround.
// Define BUS_ARB_TIMEOUT_EN to bound each grant to HOLD_MAX cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTERS  = 2,
  parameter int HOLD_MAX = 256
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [MASTERS-1:0]         arbSend,
  output logic [MASTERS-1:0]         arbCont,
  output logic [$clog2(MASTERS)-1:0] owner,
  output logic                       busy,
  output logic                       timeout
);

  localparam int              ID_W       = MASTER_ID_W(MASTERS);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(MASTERS - 1);

  generate
    if (MASTERS < 2 || MASTERS > 4 || HOLD_MAX < 1) begin : g_param_check
      $error("bus_arbiter: MASTERS must be 2..4 and HOLD_MAX at least 1");
    end
  endgenerate

  arb_state_t      state_reg, state_next;
  logic [ID_W-1:0] owner_reg, owner_next;
  logic [ID_W-1:0] last_owner_reg, last_owner_next;
  logic [ID_W-1:0] rr_winner;
  logic            rr_valid;
  logic            hold_expire;

  rr_select #(.MASTERS(MASTERS)) u_rr_select (
    .req        (arbSend),
    .last_owner (last_owner_reg),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              timeout_reg;

  // Expire while the count is one short so the grant lasts exactly HOLD_MAX cycles.
  assign hold_expire = (hold_cnt_reg == HOLD_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= (state_reg == ARB_GRANT) ? hold_cnt_reg + 1'b1 : '0;
      timeout_reg  <= (state_reg == ARB_GRANT) && arbSend[owner_reg] && hold_expire;
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (rr_valid) begin
          state_next = ARB_GRANT;
          owner_next = rr_winner;
        end
      end
      ARB_GRANT: begin
        if (!arbSend[owner_reg] || hold_expire) begin
          state_next      = ARB_RELEASE;
          last_owner_next = owner_reg;
        end
      end
      ARB_RELEASE: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= '0;
      last_owner_reg <= LAST_RESET;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Grants decode from registered state only, keeping arbSend off the output path.
  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_cont
      assign arbCont[gi] = (state_reg == ARB_GRANT) && (owner_reg == ID_W'(gi));
    end
  endgenerate

  assign busy  = (state_reg == ARB_GRANT);
  assign owner = owner_reg;

endmodule
